// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the bridge FSM state encodings.
package axi_pkg;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_END
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        W_END
    } wr_state_t;

endpackage

// File: rtl/axi_master_bridge.sv
// Arbiter read/write requests to AXI4 INCR bursts, one outstanding per direction.
module axi_master_bridge
    import axi_pkg::*;
#(
    parameter int                  AXI_ID_W = 4,
    parameter logic [AXI_ID_W-1:0] RD_ID    = '0,
    parameter logic [AXI_ID_W-1:0] WR_ID    = {{(AXI_ID_W-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                rst,
    // arbiter side
    input  logic                axi_ce_i,
    input  logic                axi_ren_i,
    input  logic                axi_rready_i,
    input  logic [31:0]         axi_raddr_i,
    input  logic [7:0]          axi_rlen_i,
    output logic [31:0]         rdata_o,
    output logic                rdata_valid_o,
    input  logic                axi_wen_i,
    input  logic [31:0]         axi_waddr_i,
    input  logic [31:0]         axi_wdata_i,
    input  logic [3:0]          axi_wsel_i,
    input  logic [7:0]          axi_wlen_i,
    input  logic                axi_wvalid_i,
    input  logic                axi_wlast_i,
    output logic                wdata_resp_o,
    output logic                bus_err_o,
    // AR
    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    // R
    input  logic [AXI_ID_W-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // AW
    output logic [AXI_ID_W-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    // W
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    // B
    input  logic [AXI_ID_W-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    rd_state_t   rd_state, rd_next;
    wr_state_t   wr_state, wr_next;
    logic [31:0] raddr_q, waddr_q;
    logic [7:0]  rlen_q, wlen_q, wcnt;
    logic [3:0]  wsel_q;

    // IDs are not checked (single outstanding) and the arbiter's wvalid/wlast
    // are informational; fold them here so they are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = ^{rid, bid, axi_wvalid_i, axi_wlast_i};

    assign arid    = RD_ID;
    assign araddr  = raddr_q;
    assign arlen   = rlen_q;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign awid    = WR_ID;
    assign awaddr  = waddr_q;
    assign awlen   = wlen_q;
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign wdata   = axi_wdata_i;
    assign wstrb   = wsel_q;

    // Read beats pass straight through to the arbiter.
    assign rdata_o       = rdata;
    assign rdata_valid_o = rvalid & rready;

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_state <= R_IDLE;
        else      rd_state <= rd_next;
    end

    // Read request latch: address/length captured at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raddr_q <= '0;
            rlen_q  <= '0;
        end else if (rd_state == R_IDLE && axi_ce_i && axi_ren_i) begin
            raddr_q <= axi_raddr_i;
            rlen_q  <= axi_rlen_i;
        end
    end

    // Read FSM next state and AR/R handshake outputs; R_END swallows the
    // still-high request in the cycle it is being dropped.
    always_comb begin
        rd_next = rd_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (rd_state)
            R_IDLE: if (axi_ce_i && axi_ren_i) rd_next = R_ADDR;
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) rd_next = R_DATA;
            end
            R_DATA: begin
                rready = axi_rready_i;
                if (rvalid && axi_rready_i && rlast) rd_next = R_END;
            end
            R_END:   rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_state <= W_IDLE;
        else      wr_state <= wr_next;
    end

    // Write request latch and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_q <= '0;
            wlen_q  <= '0;
            wsel_q  <= '0;
            wcnt    <= '0;
        end else if (wr_state == W_IDLE && axi_ce_i && axi_wen_i) begin
            waddr_q <= axi_waddr_i;
            wlen_q  <= axi_wlen_i;
            wsel_q  <= axi_wsel_i;
            wcnt    <= '0;
        end else if (wr_state == W_DATA && wready) begin
            wcnt    <= wcnt + 8'd1;
        end
    end

    // Write FSM next state and AW/W/B outputs. The last W beat gives no
    // resp pulse; that pulse is deferred to B so the arbiter's final pulse
    // means the write is complete.
    always_comb begin
        wr_next      = wr_state;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        wlast        = 1'b0;
        bready       = 1'b0;
        wdata_resp_o = 1'b0;
        case (wr_state)
            W_IDLE: if (axi_ce_i && axi_wen_i) wr_next = W_ADDR;
            W_ADDR: begin
                awvalid = 1'b1;
                if (awready) wr_next = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (wcnt == wlen_q);
                if (wready) begin
                    if (wcnt == wlen_q) wr_next = W_RESP;
                    else                wdata_resp_o = 1'b1;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    wdata_resp_o = 1'b1;
                    wr_next      = W_END;
                end
            end
            W_END:   wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Sticky error flag on any non-OKAY read or write response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_o <= 1'b0;
        end else if ((rvalid && rready && rresp != RESP_OKAY) ||
                     (bvalid && bready && bresp != RESP_OKAY)) begin
            bus_err_o <= 1'b1;
        end
    end

endmodule
